// File: rtl/multicycle_ctrl_if.sv
// Handshake bundle between the multicycle controller and the RV32I datapath/memory.
// The master modport is the controller side; the slave modport is the datapath side.
interface multicycle_ctrl_if;
  logic [31:0] instr;
  logic        Zero;
  logic        mem_ready;
  logic        PCSrc;
  logic        ALUSrc;
  logic [1:0]  ImmSel;
  logic        RegWrite;
  logic        MemToReg;
  logic [3:0]  ALUCtrl;
  logic        loadPC;
  logic        MemRead;
  logic        MemWrite;
  logic        illegal_instr;
  logic [31:0] retired;

  modport master (
    input  instr, Zero, mem_ready,
    output PCSrc, ALUSrc, ImmSel, RegWrite, MemToReg, ALUCtrl,
           loadPC, MemRead, MemWrite, illegal_instr, retired
  );

  modport slave (
    output instr, Zero, mem_ready,
    input  PCSrc, ALUSrc, ImmSel, RegWrite, MemToReg, ALUCtrl,
           loadPC, MemRead, MemWrite, illegal_instr, retired
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM: latches the instruction, steps IF/ID/EX/MEM/WB,
// drives datapath controls and memory strobes, and counts retired instructions.
//
//   state | meaning
//   IF    | latch instr into IR
//   ID    | decode IR; illegal encodings skip to next PC
//   EX    | ALU operation; branches resolve and retire here
//   MEM   | data memory access, held until mem_ready
//   WB    | register write-back, PC+4, retire
module multicycle_ctrl #(
  parameter logic [6:0] OPC_R  = 7'b0110011,
  parameter logic [6:0] OPC_I  = 7'b0010011,
  parameter logic [6:0] OPC_LW = 7'b0000011,
  parameter logic [6:0] OPC_SW = 7'b0100011,
  parameter logic [6:0] OPC_BR = 7'b1100011
) (
  input  logic              clk,
  input  logic              rst,
  multicycle_ctrl_if.master bus
);

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SRL = 4'b1000;
  localparam logic [3:0] ALU_SLL = 4'b1001;
  localparam logic [3:0] ALU_SRA = 4'b1010;
  localparam logic [3:0] ALU_XOR = 4'b1101;

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  state_t      state;
  logic [31:0] ir;
  logic [31:0] retired_q;

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       is_r, is_i, is_lw, is_sw, is_br;
  logic       bad;
  logic [3:0] alu_dec;
  logic       unused_ir_bits;

  assign opc   = ir[6:0];
  assign f3    = ir[14:12];
  assign f7    = ir[31:25];
  assign is_r  = (opc == OPC_R);
  assign is_i  = (opc == OPC_I);
  assign is_lw = (opc == OPC_LW);
  assign is_sw = (opc == OPC_SW);
  assign is_br = (opc == OPC_BR);
  assign unused_ir_bits = ^{ir[24:15], ir[11:7]};

  // funct7 only matters for R-type and for I-type shifts; sltu/sltiu have no ALU code.
  always_comb begin
    alu_dec = ALU_ADD;
    bad     = 1'b0;
    case (opc)
      OPC_R: begin
        if (f7 != 7'h00 && f7 != 7'h20) bad = 1'b1;
        if (f7 == 7'h20 && f3 != 3'b000 && f3 != 3'b101) bad = 1'b1;
        case (f3)
          3'b000:  alu_dec = f7[5] ? ALU_SUB : ALU_ADD;
          3'b001:  alu_dec = ALU_SLL;
          3'b010:  alu_dec = ALU_SLT;
          3'b100:  alu_dec = ALU_XOR;
          3'b101:  alu_dec = f7[5] ? ALU_SRA : ALU_SRL;
          3'b110:  alu_dec = ALU_OR;
          3'b111:  alu_dec = ALU_AND;
          default: bad = 1'b1;
        endcase
      end
      OPC_I: begin
        case (f3)
          3'b000:  alu_dec = ALU_ADD;
          3'b001: begin
            alu_dec = ALU_SLL;
            bad     = (f7 != 7'h00);
          end
          3'b010:  alu_dec = ALU_SLT;
          3'b100:  alu_dec = ALU_XOR;
          3'b101: begin
            alu_dec = f7[5] ? ALU_SRA : ALU_SRL;
            bad     = (f7 != 7'h00 && f7 != 7'h20);
          end
          3'b110:  alu_dec = ALU_OR;
          3'b111:  alu_dec = ALU_AND;
          default: bad = 1'b1;
        endcase
      end
      OPC_LW, OPC_SW: alu_dec = ALU_ADD;
      OPC_BR: begin
        alu_dec = ALU_SUB;
        bad     = (f3 != 3'b000);
      end
      default: bad = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IF;
      ir        <= 32'd0;
      retired_q <= 32'd0;
    end else begin
      case (state)
        S_IF: begin
          ir    <= bus.instr;
          state <= S_ID;
        end
        S_ID: state <= bad ? S_IF : S_EX;
        S_EX: begin
          if (is_br) begin
            retired_q <= retired_q + 32'd1;
            state     <= S_IF;
          end else if (is_lw || is_sw) begin
            state <= S_MEM;
          end else begin
            state <= S_WB;
          end
        end
        S_MEM: begin
          if (bus.mem_ready) begin
            if (is_sw) begin
              retired_q <= retired_q + 32'd1;
              state     <= S_IF;
            end else begin
              state <= S_WB;
            end
          end
        end
        S_WB: begin
          retired_q <= retired_q + 32'd1;
          state     <= S_IF;
        end
        default: state <= S_IF;
      endcase
    end
  end

  // Operand selection is held from EX to the end of the instruction so the ALU result is stable at WB.
  always_comb begin
    bus.PCSrc         = 1'b0;
    bus.ALUSrc        = 1'b0;
    bus.ImmSel        = 2'b00;
    bus.RegWrite      = 1'b0;
    bus.MemToReg      = 1'b0;
    bus.ALUCtrl       = ALU_ADD;
    bus.loadPC        = 1'b0;
    bus.MemRead       = 1'b0;
    bus.MemWrite      = 1'b0;
    bus.illegal_instr = 1'b0;
    if (state == S_EX || state == S_MEM || state == S_WB) begin
      bus.ALUCtrl = alu_dec;
      bus.ALUSrc  = is_i || is_lw || is_sw;
      bus.ImmSel  = is_sw ? 2'b01 : (is_br ? 2'b10 : 2'b00);
    end
    case (state)
      S_ID: begin
        bus.illegal_instr = bad;
        bus.loadPC        = bad;
      end
      S_EX: begin
        bus.loadPC = is_br;
        bus.PCSrc  = is_br && bus.Zero;
      end
      S_MEM: begin
        bus.MemRead  = is_lw;
        bus.MemWrite = is_sw;
        bus.loadPC   = is_sw && bus.mem_ready;
      end
      S_WB: begin
        bus.RegWrite = 1'b1;
        bus.MemToReg = is_lw;
        bus.loadPC   = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.retired = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Random and directed instruction streams for multicycle_ctrl, checked per cycle
// against an instruction-level reference of expected phases and control values.
module tb_multicycle_ctrl;

  localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BR = 4, K_ILL = 5;
  localparam int P_IF = 0, P_ID = 1, P_EX = 2, P_MEM = 3, P_WB = 4;
  localparam logic [3:0] A_AND = 4'b0000, A_OR = 4'b0001, A_ADD = 4'b0010, A_SUB = 4'b0110,
                         A_SLT = 4'b0111, A_SRL = 4'b1000, A_SLL = 4'b1001, A_SRA = 4'b1010,
                         A_XOR = 4'b1101;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multicycle_ctrl_if bus ();
  multicycle_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_ret;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // {PCSrc,ALUSrc,ImmSel,RegWrite,MemToReg,ALUCtrl,loadPC,MemRead,MemWrite,illegal_instr}
  function automatic logic [31:0] observed();
    return {18'd0, bus.PCSrc, bus.ALUSrc, bus.ImmSel, bus.RegWrite, bus.MemToReg,
            bus.ALUCtrl, bus.loadPC, bus.MemRead, bus.MemWrite, bus.illegal_instr};
  endfunction

  function automatic logic [31:0] pack(input logic pcsrc, input logic alusrc, input logic [1:0] imm,
                                       input logic rw, input logic m2r, input logic [3:0] alu,
                                       input logic lpc, input logic mr, input logic mw, input logic ill);
    return {18'd0, pcsrc, alusrc, imm, rw, m2r, alu, lpc, mr, mw, ill};
  endfunction

  // Instruction-set view: which instruction is it, and which ALU operation does it need.
  function automatic void classify(input logic [31:0] ins, output int kind, output logic [3:0] alu);
    logic [6:0] f7;
    logic [2:0] f3;
    f7 = ins[31:25];
    f3 = ins[14:12];
    alu = A_ADD;
    kind = K_ILL;
    case (ins[6:0])
      7'b0110011: begin
        kind = K_R;
        case ({f7, f3})
          {7'h00, 3'd0}: alu = A_ADD;
          {7'h20, 3'd0}: alu = A_SUB;
          {7'h00, 3'd1}: alu = A_SLL;
          {7'h00, 3'd2}: alu = A_SLT;
          {7'h00, 3'd4}: alu = A_XOR;
          {7'h00, 3'd5}: alu = A_SRL;
          {7'h20, 3'd5}: alu = A_SRA;
          {7'h00, 3'd6}: alu = A_OR;
          {7'h00, 3'd7}: alu = A_AND;
          default:       kind = K_ILL;
        endcase
      end
      7'b0010011: begin
        kind = K_I;
        case (f3)
          3'd0: alu = A_ADD;
          3'd2: alu = A_SLT;
          3'd4: alu = A_XOR;
          3'd6: alu = A_OR;
          3'd7: alu = A_AND;
          3'd1: if (f7 == 7'h00) alu = A_SLL; else kind = K_ILL;
          3'd5: if (f7 == 7'h00) alu = A_SRL; else if (f7 == 7'h20) alu = A_SRA; else kind = K_ILL;
          default: kind = K_ILL;
        endcase
      end
      7'b0000011: kind = K_LW;
      7'b0100011: kind = K_SW;
      7'b1100011: begin
        if (f3 == 3'd0) begin
          kind = K_BR;
          alu  = A_SUB;
        end
      end
      default: kind = K_ILL;
    endcase
  endfunction

  // Runs one instruction; abort_mem >= 0 asserts rst after that MEM cycle instead of finishing.
  task automatic run_instr(input string name, input logic [31:0] ins, input logic zero,
                           input int stalls, input int abort_mem);
    int kind;
    logic [3:0] alu;
    int phases[$];
    int memk;
    logic alusrc;
    logic [1:0] imm;
    logic [31:0] exp;
    logic retire;
    logic mrdy;
    classify(ins, kind, alu);
    phases.push_back(P_IF);
    phases.push_back(P_ID);
    if (kind != K_ILL) begin
      phases.push_back(P_EX);
      if (kind == K_LW || kind == K_SW)
        for (int k = 0; k <= stalls; k++) phases.push_back(P_MEM);
      if (kind == K_R || kind == K_I || kind == K_LW) phases.push_back(P_WB);
    end
    alusrc = (kind == K_I || kind == K_LW || kind == K_SW);
    imm    = (kind == K_SW) ? 2'b01 : (kind == K_BR) ? 2'b10 : 2'b00;
    memk   = 0;
    foreach (phases[c]) begin
      bus.instr     = (phases[c] == P_IF) ? ins : $urandom;
      bus.Zero      = (phases[c] == P_EX) ? zero : 1'($urandom);
      mrdy          = (phases[c] == P_MEM) ? (memk == stalls) : 1'($urandom);
      bus.mem_ready = mrdy;
      retire = 1'b0;
      case (phases[c])
        P_IF:  exp = pack(0, 0, 2'b00, 0, 0, A_ADD, 0, 0, 0, 0);
        P_ID:  exp = (kind == K_ILL) ? pack(0, 0, 2'b00, 0, 0, A_ADD, 1, 0, 0, 1)
                                     : pack(0, 0, 2'b00, 0, 0, A_ADD, 0, 0, 0, 0);
        P_EX: begin
          exp = pack((kind == K_BR) && zero, alusrc, imm, 0, 0, alu, kind == K_BR, 0, 0, 0);
          retire = (kind == K_BR);
        end
        P_MEM: begin
          exp = pack(0, alusrc, imm, 0, 0, alu, (kind == K_SW) && mrdy,
                     kind == K_LW, kind == K_SW, 0);
          retire = (kind == K_SW) && mrdy;
        end
        default: begin
          exp = pack(0, alusrc, imm, 1, kind == K_LW, alu, 1, 0, 0, 0);
          retire = 1'b1;
        end
      endcase
      #2;
      check_val($sformatf("%s_c%0d_ctl", name, c), observed(), exp);
      check_val($sformatf("%s_c%0d_ret", name, c), bus.retired, exp_ret);
      if (retire) exp_ret = exp_ret + 32'd1;
      if (phases[c] == P_MEM) begin
        if (memk == abort_mem) begin
          rst = 1'b1;
          @(posedge clk);
          #1;
          rst = 1'b0;
          exp_ret = 32'd0;
          check_val({name, "_abort_ctl"}, observed(), pack(0, 0, 2'b00, 0, 0, A_ADD, 0, 0, 0, 0));
          check_val({name, "_abort_ret"}, bus.retired, exp_ret);
          return;
        end
        memk++;
      end
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    logic [6:0] opcs[7];
    opcs = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b0110011, 7'b0010011};
    ins = $urandom;
    if ($urandom_range(0, 7) != 0) ins[6:0] = opcs[$urandom_range(0, 6)];
    if ($urandom_range(0, 4) != 0) ins[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
    if (ins[6:0] == 7'b1100011 && $urandom_range(0, 2) != 0) ins[14:12] = 3'd0;
    return ins;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    bus.instr = 32'hFFFF_FFFF;
    bus.Zero = 1'b1;
    bus.mem_ready = 1'b1;
    exp_ret = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_val("reset_ctl", observed(), pack(0, 0, 2'b00, 0, 0, A_ADD, 0, 0, 0, 0));
    check_val("reset_ret", bus.retired, 32'd0);

    run_instr("add",    32'h002081B3, 1'b0, 0, -1);
    run_instr("lw",     32'h0080A283, 1'b0, 3, -1);
    run_instr("sw",     32'h0050A223, 1'b0, 0, -1);
    run_instr("sw_st",  32'h0050A223, 1'b1, 2, -1);
    run_instr("beq_z1", 32'h00208463, 1'b1, 0, -1);
    run_instr("beq_z0", 32'h00208463, 1'b0, 0, -1);
    run_instr("ill",    32'hFFFF_FFFF, 1'b0, 0, -1);
    run_instr("sra",    32'h4020D1B3, 1'b0, 0, -1);
    run_instr("srai",   32'h4030D093, 1'b0, 0, -1);
    run_instr("sltu",   32'h0020B1B3, 1'b0, 0, -1);
    run_instr("bne",    32'h00209463, 1'b1, 0, -1);

    for (int n = 0; n < 300; n++)
      run_instr($sformatf("rnd%0d", n), rand_instr(), 1'($urandom), int'($urandom_range(0, 3)), -1);

    run_instr("lw_abort", 32'h0080A283, 1'b0, 5, 1);
    run_instr("add_post", 32'h002081B3, 1'b0, 0, -1);
    check_val("final_ret", bus.retired, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multicycle control FSM for the RV32I datapath.
- Latches the fetched instruction and sequences each instruction through IF/ID/EX/MEM/WB.
- Drives the datapath's PCSrc, ALUSrc, RegWrite, MemToReg, ALUCtrl and loadPC, plus data-memory strobes.
- Waits on a data-memory ready handshake and counts retired instructions.

Parameters:
- OPC_R, 7'b0110011, R-type ALU opcode.
- OPC_I, 7'b0010011, I-type ALU opcode.
- OPC_LW, 7'b0000011, load opcode.
- OPC_SW, 7'b0100011, store opcode.
- OPC_BR, 7'b1100011, branch opcode.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  synchronous, active-high reset.
- instr  in  32  instruction word from ROM at current PC.
- Zero  in  1  ALU zero flag from datapath.
- mem_ready  in  1  data memory has completed the current read/write.
- PCSrc  out  1  1 = branch target, 0 = PC+4.
- ALUSrc  out  1  1 = immediate operand.
- ImmSel  out  2  00 = I, 01 = S, 10 = B.
- RegWrite  out  1  register-file write enable.
- MemToReg  out  1  write-back from memory.
- ALUCtrl  out  4  ALU operation.
- loadPC  out  1  PC update strobe.
- MemRead  out  1  data read strobe.
- MemWrite  out  1  data write strobe.
- illegal_instr  out  1  one-cycle pulse on an unsupported encoding.
- retired  out  32  retired-instruction count.

Behaviour:
- Reset: rst=1 at a clk edge forces state=IF, IR=0, retired=0. Outputs are Moore-decoded from state and IR, so in IF all strobes are 0, ALUCtrl=ADD (0010), ALUSrc=0, ImmSel=00, PCSrc=0.
- rst mid-instruction aborts it immediately. No strobe is asserted in the cycle after reset.
- ALUCtrl codes:
  - AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, SRL 1000, SLL 1001, SRA 1010, XOR 1101.
  - R: funct3/funct7[5] select among add/sub/and/or/xor/slt/sll/srl/sra.
  - I: addi/andi/ori/xori/slti/slli/srli/srai. funct7[5] is used only for the shift distinction.
  - LW, SW: ADD.
  - BEQ (funct3=000): SUB.
- States: IF=0, ID=1, EX=2, MEM=3, WB=4 (3-bit encoding).
  - IF: IR <= instr at the clk edge; next state ID.
  - ID: decode IR.
    - Illegal opcode, BR with funct3≠000, or invalid funct7: pulse illegal_instr and loadPC=1 with PCSrc=0 (skip); next state IF; retired unchanged.
    - Otherwise next state EX.
  - EX: ALUCtrl/ALUSrc/ImmSel driven from IR.
    - BR: loadPC=1, PCSrc=Zero; retire; next state IF.
    - LW/SW: next state MEM.
    - R/I: next state WB.
  - MEM: LW asserts MemRead=1; SW asserts MemWrite=1. Hold MEM while mem_ready=0.
    - mem_ready=1, SW: loadPC=1; retire; next state IF.
    - mem_ready=1, LW: next state WB.
  - WB: RegWrite=1, MemToReg=(LW), loadPC=1, PCSrc=0; retire; next state IF.
- ALUCtrl, ALUSrc and ImmSel are held constant from EX through the final state of the instruction so the ALU result stays stable at write-back.
  - ALUSrc=1, ImmSel=00 for I and LW.
  - ALUSrc=1, ImmSel=01 for SW.
  - ALUSrc=0, ImmSel=10 for BR.
  - ALUSrc=0 for R.
- Latency in cycles, with mem_ready=1: R/I=4, LW=5, SW=4, BR=3, illegal=2. Each cycle of mem_ready=0 adds one cycle.
- loadPC is asserted for exactly one cycle per instruction. RegWrite and MemWrite never overlap.
- retired increments by 1 in each retiring cycle and wraps from 0xFFFFFFFF to 0.
- instr is sampled only in IF; changes to instr in other states are ignored.
- mem_ready is ignored outside MEM.

Test Plan:
- Reset, then add x3,x1,x2 (0x002081B3) with rst released → states IF,ID,EX,WB. ALUCtrl=0010, RegWrite=1 and loadPC=1 in cycle 4 only, retired=1.
- lw x5,8(x1) (0x0080A283) with mem_ready low for 3 cycles → MemRead high for 4 cycles. WB has MemToReg=1, RegWrite=1. Total 8 cycles.
- sw x5,4(x1) (0x0050A223) → ALUSrc=1, ImmSel=01, MemWrite=1 in MEM, loadPC=1 in MEM, RegWrite never set.
- beq x1,x2,+8 (0x00208463):
  - Zero=1 → EX has ALUCtrl=0110, PCSrc=1, loadPC=1, 3-cycle latency.
  - Repeat with Zero=0 → PCSrc=0.
- instr=0xFFFFFFFF → illegal_instr pulse in ID, loadPC=1, retired unchanged, back to IF.
- Assert rst during MEM of a stalled lw → next cycle state=IF, MemRead=0, retired=0.
